// File: rtl/dht22_poller.sv
// ---------------------------------------------------------------------------
// dht22_poller
//
// Scheduler that sits in front of the single-wire DHT22 reader. It starts a
// read periodically (enable) or on request (trig), keeps successive read
// starts at least PERIOD_CYC apart, waits for the reader to return a frame or
// time out, checks the frame checksum and retries failed attempts. Only frames
// that pass the checksum are published on humidity/temperature.
//
// Parameters
//   PERIOD_CYC   minimum cycles between read starts; also the power-up holdoff
//   TIMEOUT_CYC  cycles allowed in WAIT for rd_done
//   GET_CYC      width of the rd_get pulse
//   MAX_RETRY    consecutive failed attempts before fail is pulsed (>= 1)
//
// Ports
//   clk          clock
//   reset        synchronous reset, active low
//   enable       periodic polling enable
//   trig         one-cycle request for a single read
//   rd_get       start request to the reader (GET_CYC cycles wide)
//   rd_done      reader frame complete; rd_data valid this cycle
//   rd_data      raw frame {hum[15:0], temp[15:0], sum[7:0]}
//   humidity     last verified humidity word
//   temperature  last verified temperature word (bit 15 = sign, raw)
//   valid        humidity/temperature hold a verified reading
//   update       one-cycle pulse when a new reading is published
//   err_crc      one-cycle pulse on checksum mismatch
//   err_timeout  one-cycle pulse on reader timeout
//   fail         one-cycle pulse when MAX_RETRY consecutive attempts fail
//   busy         high while in TRIGGER, WAIT or CHECK
// ---------------------------------------------------------------------------
module dht22_poller #(
    parameter int unsigned PERIOD_CYC  = 100_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000,
    parameter int unsigned GET_CYC     = 4,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        trig,
    output logic        rd_get,
    input  logic        rd_done,
    input  logic [39:0] rd_data,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        valid,
    output logic        update,
    output logic        err_crc,
    output logic        err_timeout,
    output logic        fail,
    output logic        busy
);

    // Retry counter only has to hold values up to MAX_RETRY.
    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [31:0]   PERIOD_LAST  = 32'(PERIOD_CYC - 1);
    localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0]   GET_LAST     = 32'(GET_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_HOLDOFF,
        S_IDLE,
        S_TRIGGER,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   timer_q, timer_d;
    logic [RW-1:0] retry_cnt_q, retry_cnt_d;
    logic          retry_pend_q, retry_pend_d;
    logic          trig_pend_q, trig_pend_d;
    logic [39:0]   shadow_q, shadow_d;

    logic          rd_get_q, rd_get_d;
    logic [15:0]   hum_q, hum_d;
    logic [15:0]   temp_q, temp_d;
    logic          valid_q, valid_d;
    logic          update_q, update_d;
    logic          err_crc_q, err_crc_d;
    logic          err_tmo_q, err_tmo_d;
    logic          fail_q, fail_d;
    logic          busy_q, busy_d;

    logic          attempt_failed;
    logic [RW-1:0] retry_inc;
    logic [7:0]    sum;
    logic          start_req;

    // Checksum over the captured frame; the 8-bit result wraps mod 256.
    assign sum = shadow_q[39:32] + shadow_q[31:24] + shadow_q[23:16] + shadow_q[15:8];

    assign retry_inc = retry_cnt_q + RW'(1);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        retry_cnt_d    = retry_cnt_q;
        retry_pend_d   = retry_pend_q;
        // A trig in any state is remembered until the next read starts.
        trig_pend_d    = trig_pend_q | trig;
        shadow_d       = shadow_q;
        hum_d          = hum_q;
        temp_d         = temp_q;
        valid_d        = valid_q;
        update_d       = 1'b0;
        err_crc_d      = 1'b0;
        err_tmo_d      = 1'b0;
        fail_d         = 1'b0;
        attempt_failed = 1'b0;
        // Includes a trig arriving this very cycle so it is not delayed.
        start_req      = enable | trig_pend_d;

        unique case (state_q)
            S_HOLDOFF: begin
                if (timer_q == PERIOD_LAST) begin
                    if (retry_pend_q || start_req) state_d = S_TRIGGER;
                    else                           state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (start_req) state_d = S_TRIGGER;
            end

            S_TRIGGER: begin
                if (timer_q == GET_LAST) state_d = S_WAIT;
            end

            S_WAIT: begin
                // rd_done has priority over a timeout landing in the same cycle.
                if (rd_done) begin
                    shadow_d = rd_data;
                    state_d  = S_CHECK;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_tmo_d      = 1'b1;
                    attempt_failed = 1'b1;
                    state_d        = S_HOLDOFF;
                end
            end

            S_CHECK: begin
                if (sum == shadow_q[7:0]) begin
                    hum_d       = shadow_q[39:24];
                    temp_d      = shadow_q[23:8];
                    valid_d     = 1'b1;
                    update_d    = 1'b1;
                    retry_cnt_d = '0;
                end else begin
                    err_crc_d      = 1'b1;
                    attempt_failed = 1'b1;
                end
                state_d = S_HOLDOFF;
            end

            default: state_d = S_HOLDOFF;
        endcase

        // Shared failure path for checksum errors and timeouts. A retry is
        // scheduled through the normal holdoff, independent of enable.
        if (attempt_failed) begin
            if (retry_inc < RETRY_LIMIT) begin
                retry_cnt_d  = retry_inc;
                retry_pend_d = 1'b1;
            end else begin
                fail_d       = 1'b1;
                valid_d      = 1'b0;
                retry_cnt_d  = '0;
                retry_pend_d = 1'b0;
            end
        end

        // Starting a read consumes any pending request.
        if (state_d == S_TRIGGER && state_q != S_TRIGGER) begin
            trig_pend_d  = 1'b0;
            retry_pend_d = 1'b0;
        end

        // Single timer, restarted on every state change.
        timer_d = (state_d != state_q) ? 32'd0 : timer_q + 32'd1;

        // Registered outputs follow the next state so they line up with it.
        rd_get_d = (state_d == S_TRIGGER);
        busy_d   = (state_d == S_TRIGGER) || (state_d == S_WAIT) || (state_d == S_CHECK);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_HOLDOFF;
            timer_q      <= 32'd0;
            retry_cnt_q  <= '0;
            retry_pend_q <= 1'b0;
            trig_pend_q  <= 1'b0;
            shadow_q     <= 40'd0;
            rd_get_q     <= 1'b0;
            hum_q        <= 16'd0;
            temp_q       <= 16'd0;
            valid_q      <= 1'b0;
            update_q     <= 1'b0;
            err_crc_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_cnt_q  <= retry_cnt_d;
            retry_pend_q <= retry_pend_d;
            trig_pend_q  <= trig_pend_d;
            shadow_q     <= shadow_d;
            rd_get_q     <= rd_get_d;
            hum_q        <= hum_d;
            temp_q       <= temp_d;
            valid_q      <= valid_d;
            update_q     <= update_d;
            err_crc_q    <= err_crc_d;
            err_tmo_q    <= err_tmo_d;
            fail_q       <= fail_d;
            busy_q       <= busy_d;
        end
    end

    assign rd_get      = rd_get_q;
    assign humidity    = hum_q;
    assign temperature = temp_q;
    assign valid       = valid_q;
    assign update      = update_q;
    assign err_crc     = err_crc_q;
    assign err_timeout = err_tmo_q;
    assign fail        = fail_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dht22_poller.sv
// ---------------------------------------------------------------------------
// tb_dht22_poller
//
// Directed bench for dht22_poller with PERIOD_CYC=100, TIMEOUT_CYC=50,
// GET_CYC=4, MAX_RETRY=2. Expected result pulses are queued as stimulus is
// applied and checked by a monitor whenever the DUT raises a result pulse.
// ---------------------------------------------------------------------------
module tb_dht22_poller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        trig;
    logic        rd_get;
    logic        rd_done;
    logic [39:0] rd_data;
    logic [15:0] humidity;
    logic [15:0] temperature;
    logic        valid;
    logic        update;
    logic        err_crc;
    logic        err_timeout;
    logic        fail;
    logic        busy;

    dht22_poller #(
        .PERIOD_CYC (100),
        .TIMEOUT_CYC(50),
        .GET_CYC    (4),
        .MAX_RETRY  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .trig       (trig),
        .rd_get     (rd_get),
        .rd_done    (rd_done),
        .rd_data    (rd_data),
        .humidity   (humidity),
        .temperature(temperature),
        .valid      (valid),
        .update     (update),
        .err_crc    (err_crc),
        .err_timeout(err_timeout),
        .fail       (fail),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // flags = {update, err_crc, err_timeout, fail}
    typedef struct {
        int          cyc;
        logic [3:0]  flags;
        logic        vld;
        logic [15:0] hum;
        logic [15:0] tmp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] f, input logic v,
                        input logic [15:0] h, input logic [15:0] t);
        exp_t e;
        e.cyc = c; e.flags = f; e.vld = v; e.hum = h; e.tmp = t;
        sb.push_back(e);
    endtask

    // Result monitor: every result pulse must match the next queued expectation.
    always @(negedge clk) begin
        if ((update | err_crc | err_timeout | fail) === 1'b1) begin
            chk("unexpected_pulse", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("res_cycle", cyc, mon_e.cyc);
                chk("res_flags", {28'd0, update, err_crc, err_timeout, fail}, {28'd0, mon_e.flags});
                chk("res_valid", {31'd0, valid}, {31'd0, mon_e.vld});
                chk("res_data", {humidity, temperature}, {mon_e.hum, mon_e.tmp});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_get"}, {31'd0, rd_get}, 32'd0);
        chk({tag, "_hum"}, {16'd0, humidity}, 32'd0);
        chk({tag, "_temp"}, {16'd0, temperature}, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_pulses"}, {28'd0, update, err_crc, err_timeout, fail}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Step negedges until rd_get is seen; at = cycle or -1 if the bound expires.
    task automatic wait_get(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (rd_get === 1'b1) begin
                at = cyc;
                return;
            end
        end
    endtask

    // Called on the first rd_get cycle; leaves us on the first low cycle.
    task automatic check_burst(input string tag);
        int n;
        n = 1;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_get !== 1'b1) break;
            n++;
        end
        chk({tag, "_get_width"}, n, 4);
    endtask

    task automatic pulse_done(input logic [39:0] d);
        rd_data = d;
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
    endtask

    // Step n negedges, counting cycles with rd_get high.
    task automatic quiet(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rd_get !== 1'b0) highs++;
        end
    endtask

    task automatic trig_pulse();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    initial begin
        int at, k, f, c0, r, x, g, n;

        reset   = 1'b0;
        enable  = 1'b1;
        trig    = 1'b0;
        rd_done = 1'b0;
        rd_data = 40'd0;

        // 1. reset state, power-up holdoff and first burst
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        c0 = cyc;
        wait_get(200, at);
        chk("s1_first_get", at, c0 + 100);
        check_burst("s1");

        // 2. good frame, next read exactly one period after CHECK
        repeat (5) @(negedge clk);
        k = cyc;
        push(k + 2, 4'b1000, 1'b1, 16'h028C, 16'h0115);
        pulse_done(40'h028C0115A4);
        wait_get(200, at);
        chk("s2_next_get", at, k + 2 + 100);

        // 3. bad checksum: outputs kept, retry even with enable low
        enable = 1'b0;
        check_burst("s3");
        k = cyc;
        push(k + 2, 4'b0100, 1'b1, 16'h028C, 16'h0115);
        pulse_done(40'h028C0115A5);
        wait_get(200, at);
        chk("s3_retry_get", at, k + 2 + 100);
        check_burst("s3r");
        k = cyc;
        push(k + 2, 4'b1000, 1'b1, 16'h01F4, 16'h8065);
        pulse_done(40'h01F48065DA);

        // 4. single trig starts a read, then two timeouts end in fail
        repeat (8) @(negedge clk);
        trig_pulse();
        wait_get(200, at);
        chk("s4_trig_get", at, k + 2 + 100);
        check_burst("s4a");
        g = cyc;
        push(g + 50, 4'b0010, 1'b1, 16'h01F4, 16'h8065);
        wait_get(200, at);
        chk("s4_retry_get", at, g + 50 + 100);
        check_burst("s4b");
        f = cyc + 50;
        push(f, 4'b0011, 1'b0, 16'h01F4, 16'h8065);

        // 5. after fail: no read by itself; three trigs collapse into one read
        quiet(55, n);                 // lands on f+5
        chk("s4_no_get_after_fail", n, 0);
        trig_pulse();                 // f+6
        quiet(14, n);                 // f+20
        trig_pulse();                 // f+21
        quiet(39, n);                 // f+60
        trig_pulse();                 // f+61
        chk("s5_no_get_in_holdoff", n, 0);
        wait_get(200, at);
        chk("s5_get", at, f + 100);
        check_burst("s5");
        k = cyc;
        push(k + 2, 4'b1000, 1'b1, 16'h0300, 16'h00FA);
        pulse_done(40'h030000FAFD);
        quiet(250, n);
        chk("s5_single_burst", n, 0);
        chk("s5_idle_busy", {31'd0, busy}, 32'd0);

        // 6. reset while in WAIT, late rd_done ignored, fresh holdoff
        x = cyc;
        enable = 1'b1;
        wait_get(10, at);
        chk("s6_get", at, x + 1);
        check_burst("s6");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("s6_rst");
        r = cyc;
        reset = 1'b1;
        @(negedge clk);
        pulse_done(40'h028C0115A4);
        wait_get(200, at);
        chk("s6_holdoff_get", at, r + 100);
        chk("s6_valid", {31'd0, valid}, 32'd0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
